// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux: load extraction, WB source select, regfile write port.
// Optional retire counter is built only when WB_RETIRE_CNT_EN is defined.
module mem_wb_stage #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int REG_BITS  = $clog2(REG_COUNT),
    parameter int RETIRE_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                in_reg_write,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic [1:0]          in_wb_sel,
    input  logic [2:0]          in_funct3,
    input  logic [WIDTH-1:0]    in_alu_result,
    input  logic [WIDTH-1:0]    in_mem_rdata,
    input  logic [WIDTH-1:0]    in_pc_plus4,
    output logic                wb_valid,
    output logic                write_en,
    output logic [REG_BITS-1:0] write_reg,
    output logic [WIDTH-1:0]    write_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [RETIRE_W-1:0] retire_count
`endif
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] wb_data;
    logic             wb_en;

    // Memory returns the aligned word; pick the addressed lane before the register.
    always_comb begin
        load_byte = 8'h00;
        case (in_alu_result[1:0])
            2'd0:    load_byte = in_mem_rdata[7:0];
            2'd1:    load_byte = in_mem_rdata[15:8];
            2'd2:    load_byte = in_mem_rdata[23:16];
            default: load_byte = in_mem_rdata[31:24];
        endcase
        load_half = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    end

    always_comb begin
        load_data = in_mem_rdata;
        case (in_funct3)
            F3_LB:   load_data = {{(WIDTH-8){load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {{(WIDTH-8){1'b0}}, load_byte};
            F3_LH:   load_data = {{(WIDTH-16){load_half[15]}}, load_half};
            F3_LHU:  load_data = {{(WIDTH-16){1'b0}}, load_half};
            default: load_data = in_mem_rdata;
        endcase
    end

    always_comb begin
        wb_data = '0;
        case (in_wb_sel)
            SEL_ALU:  wb_data = in_alu_result;
            SEL_LOAD: wb_data = load_data;
            SEL_LINK: wb_data = in_pc_plus4;
            default:  wb_data = '0;
        endcase
    end

    // x0 is never written, so forwarding from WB can never supply a non-zero x0.
    assign wb_en = in_valid & in_reg_write & (in_rd != '0) & (in_wb_sel != 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (!stall) begin
            wb_valid   <= in_valid;
            write_en   <= wb_en;
            write_reg  <= in_rd;
            write_data <= wb_data;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Counts every instruction entering WB, including x0 targets and no-writeback ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (!flush && !stall && in_valid) begin
            retire_count <= retire_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage with a behavioural writeback model.
// Retire-counter checks are compiled in only when WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;

`ifdef WB_RETIRE_CNT_EN
    localparam int RW = 4;
`else
    localparam int RW = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_mem_rdata = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic        wb_valid;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef WB_RETIRE_CNT_EN
    logic [RW-1:0] retire_count;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic        m_valid, m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    longint      m_cnt;
    logic [31:0] regs [32];

    mem_wb_stage #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
        .wb_valid(wb_valid), .write_en(write_en), .write_reg(write_reg),
        .write_data(write_data)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected writeback value from the ISA description: shift the word, mask, then sign-adjust.
    function automatic logic [31:0] model_data(input logic [1:0] sel, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc4);
        longint v;
        if (sel == 2'd0) return alu;
        if (sel == 2'd2) return pc4;
        if (sel == 2'd3) return 32'd0;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = longint'(rdata >> (8 * alu[1:0])) % 256;
            if (f3 == 3'd0 && v >= 128) v -= 256;
            return 32'(v);
        end
        if (f3 == 3'd1 || f3 == 3'd5) begin
            v = longint'(rdata >> (16 * alu[1])) % 65536;
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
            return 32'(v);
        end
        return rdata;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_en <= 1'b0; m_reg <= '0; m_data <= '0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 1'b0; m_en <= 1'b0; m_reg <= '0; m_data <= '0;
        end else if (!stall) begin
            m_valid <= in_valid;
            m_en    <= in_valid && in_reg_write && in_rd != 0 && in_wb_sel != 2'd3;
            m_reg   <= in_rd;
            m_data  <= model_data(in_wb_sel, in_funct3, in_alu_result, in_mem_rdata, in_pc_plus4);
            if (in_valid) m_cnt <= (m_cnt + 1) % (longint'(1) << RW);
        end
    end

    // Bench-side regfile sampling the write port on negedge.
    always @(negedge clk) begin
        if (write_en === 1'b1 && write_reg != 0) regs[write_reg] <= write_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
            check("write_en", {31'd0, write_en}, {31'd0, m_en});
            check("write_reg", {27'd0, write_reg}, {27'd0, m_reg});
            check("write_data", write_data, m_data);
`ifdef WB_RETIRE_CNT_EN
            check("retire_count", 32'(retire_count), 32'(m_cnt));
`endif
        end
    end

    task automatic set_in(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pc4, input logic st, input logic fl);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4; stall = st; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_en"}, {31'd0, write_en}, 32'd0);
        check({tag, "_reg"}, {27'd0, write_reg}, 32'd0);
        check({tag, "_data"}, write_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check({tag, "_cnt"}, 32'(retire_count), 32'd0);
`endif
    endtask

    logic [31:0] golden, imm;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        for (int i = 0; i < 16; i++) begin
            set_in(1, 1, 5'd3, 2'd0, 3'd0, i, 0, 0, 0, 0); step();
        end
        set_in(1, 1, 5'd3, 2'd0, 3'd0, 0, 0, 0, 1, 0); step(); step();
        set_in(1, 1, 5'd3, 2'd0, 3'd0, 0, 0, 0, 0, 1); step();
        set_in(0, 1, 5'd3, 2'd0, 3'd0, 0, 0, 0, 0, 0); step(); step();
        check("retire_wrap", 32'(retire_count), 32'd0);
        set_in(1, 0, 5'd0, 2'd3, 3'd0, 0, 0, 0, 0, 0); step();
        check("retire_one", 32'(retire_count), 32'd1);
`endif

        set_in(1, 1, 5'd7, 2'd1, 3'b000, 32'h3, 32'h80FF_1234, 0, 0, 0); step();
        check("lb", write_data, 32'hFFFF_FF80);
        set_in(1, 1, 5'd7, 2'd1, 3'b100, 32'h3, 32'h80FF_1234, 0, 0, 0); step();
        check("lbu", write_data, 32'h0000_0080);
        set_in(1, 1, 5'd7, 2'd1, 3'b001, 32'h2, 32'h80FF_1234, 0, 0, 0); step();
        check("lh", write_data, 32'hFFFF_80FF);
        set_in(1, 1, 5'd7, 2'd1, 3'b101, 32'h1, 32'h80FF_1234, 0, 0, 0); step();
        check("lhu", write_data, 32'h0000_1234);

        set_in(1, 1, 5'd1, 2'd2, 3'd0, 32'h999, 0, 32'h104, 0, 0); step();
        check("jal_en", {31'd0, write_en}, 32'd1);
        check("jal_reg", {27'd0, write_reg}, 32'd1);
        check("jal_data", write_data, 32'h104);
        set_in(1, 1, 5'd0, 2'd2, 3'd0, 32'h999, 0, 32'h104, 0, 0); step();
        check("jal_x0_en", {31'd0, write_en}, 32'd0);
        check("jal_x0_valid", {31'd0, wb_valid}, 32'd1);

        set_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h55, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 5'd9, 2'd0, 3'd0, $urandom, 0, 0, 1, 0); step();
            check("stall_data", write_data, 32'h55);
            check("stall_reg", {27'd0, write_reg}, 32'd5);
        end
        set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'h77, 0, 0, 1, 1); step();
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_en", {31'd0, write_en}, 32'd0);

        golden = regs[6];
        for (int i = 0; i < 8; i++) begin
            imm = $urandom_range(0, 4095);
            set_in(1, 1, 5'd6, 2'd0, 3'd0, golden + imm, $urandom, 0, 0, 0);
            golden = golden + imm;
            step();
            @(negedge clk); #1;
            check("addi_x6", regs[6], golden);
        end

        set_in(1, 1, 5'd12, 2'd0, 3'd0, 32'hABCD, 0, 0, 0, 0); step();
        check("pre_rst_en", {31'd0, write_en}, 32'd1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        step();
        check_zero("held_rst");
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
